// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous UART receiver, LSB first.
//   Synchronises the serial line, qualifies the start bit at mid-bit, samples each data
//   bit at mid-bit, checks the stop bit and presents the byte with a one-cycle strobe.
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous reset, active low
//   rx_din     serial line, idle high, asynchronous to sys_clk
//   rx_dout    last correctly framed byte, held until the next good frame
//   rx_done    one-cycle pulse, rx_dout updated this cycle
//   rx_busy    high while a frame is in progress
//   rx_err     one-cycle pulse, stop bit sampled low
module uart_rx #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx_din,
  output logic [7:0] rx_dout,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       rx_err
);

  localparam int unsigned BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam int unsigned HALF_CNT = BPS_CNT / 2;
  localparam int unsigned CntW     = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(BPS_CNT - 1);
  localparam logic [CntW-1:0] BaudHalf = CntW'(HALF_CNT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_s1_q, rx_s_q, rx_d_q;
  logic [7:0]      dout_d;
  logic            done_d, err_d, busy_d;
  logic            start_edge, data_tick, stop_tick;

  // Synchroniser plus delay flop; all reset high so releasing reset with an idle line
  // never looks like a falling edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      rx_s1_q <= rx_din;
      rx_s_q  <= rx_s1_q;
      rx_d_q  <= rx_s_q;
    end
  end

  assign start_edge = rx_d_q & ~rx_s_q;
  assign data_tick  = (state_q == StData) && (baud_q == BaudLast);
  assign stop_tick  = (state_q == StStop) && (baud_q == BaudLast);

  // State register and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_edge) state_d = StStart;
      // A line that is high again at mid start bit was a glitch.
      StStart: if (baud_q == BaudHalf) state_d = rx_s_q ? StIdle : StData;
      StData:  if (data_tick && (bit_q == 3'd7)) state_d = StStop;
      // Leave at mid stop bit so a back-to-back start edge is not missed.
      StStop:  if (stop_tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Counters and shift register next-state
  always_comb begin
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    if ((state_d != state_q) || (baud_q == BaudLast)) baud_d = '0;
    if (state_q != StData) begin
      bit_d = '0;
    end else if (data_tick) begin
      bit_d          = bit_q + 1'b1;
      shift_d[bit_q] = rx_s_q;
    end
  end

  // Output logic, registered below
  always_comb begin
    dout_d = rx_dout;
    done_d = 1'b0;
    err_d  = 1'b0;
    busy_d = (state_d != StIdle);
    if (stop_tick) begin
      if (rx_s_q) begin
        dout_d = shift_q;
        done_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_dout <= 8'h00;
      rx_done <= 1'b0;
      rx_err  <= 1'b0;
      rx_busy <= 1'b0;
    end else begin
      rx_dout <= dout_d;
      rx_done <= done_d;
      rx_err  <= err_d;
      rx_busy <= busy_d;
    end
  end

endmodule
